muldiv_iter: RTL and testbench

Iterative RV32M/RV64M multiply-divide unit for the execute stage. It implements all eight M-extension ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. The execute stage drives req_i and holds its stall while req_i is high and ready_o is low. This block supersedes the multiply-only unit: it adds division, signed fix-up inside the unit, a configurable multiply radix, fast paths and flush.

---
 rtl/muldiv_iter_pkg.sv | 34 +++
 rtl/md_negate.sv | 16 +
 rtl/muldiv_iter.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the M-extension funct3 op encodings, the FSM state encoding and
// small decode helpers used by muldiv_iter.
package muldiv_iter_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIXUP,
        ST_DONE
    } md_state_e;

    // rs1 is interpreted as signed for these ops
    function automatic logic op_a_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is interpreted as signed for these ops
    function automatic logic op_b_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement negate of a W-bit value.
// Ports:
//   value_i  : operand
//   neg_i    : 1 = output -value_i, 0 = pass through
//   result_o : (possibly negated) value, modulo 2^W
module md_negate #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value_i,
    input  logic         neg_i,
    output logic [W-1:0] result_o
);

    assign result_o = neg_i ? ('0 - value_i) : value_i;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply-divide unit.
// Multiplies by unsigned shift-add (MUL_STEP multiplier bits per cycle),
// divides by restoring division (one quotient bit per cycle), then applies
// the sign fix-up in a single FIXUP cycle. Trivial operand combinations
// (zero multiplicand, divide by zero, signed overflow) bypass CALC.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous reset, active low
//   req_i    : request, operands valid while high
//   op_i     : funct3 op encoding (md_op_e)
//   a_i, b_i : rs1 / rs2 operands
//   flush_i  : abort the current op, return to IDLE
//   busy_o   : unit not idle
//   ready_o  : one-cycle pulse, result_o valid
//   result_o : registered result
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned     CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(XLEN / MUL_STEP - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    md_op_e            op_q;
    logic              a_neg_q, b_neg_q;
    logic [XLEN-1:0]   opnd_q;     // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc_q;      // mul: {partial product, multiplier}; div: low half = dividend/quotient
    logic [XLEN-1:0]   rem_q;      // div partial remainder
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    md_op_e          op_in;
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            accept;
    logic            fast_hit;
    logic [XLEN-1:0] fast_val;

    assign op_in    = md_op_e'(op_i);
    assign a_neg_in = op_a_signed(op_in) & a_i[XLEN-1];
    assign b_neg_in = op_b_signed(op_in) & b_i[XLEN-1];
    assign accept   = (state_q == ST_IDLE) && req_i && !flush_i;

    md_negate #(.W(XLEN)) u_neg_a (.value_i(a_i), .neg_i(a_neg_in), .result_o(a_abs));
    md_negate #(.W(XLEN)) u_neg_b (.value_i(b_i), .neg_i(b_neg_in), .result_o(b_abs));

    always_comb begin
        fast_hit = 1'b0;
        fast_val = '0;
        if (!op_in[2]) begin
            if (a_i == '0 || b_i == '0) begin
                fast_hit = 1'b1;
            end
        end else if (b_i == '0) begin
            // op_in[1] selects REM/REMU
            fast_hit = 1'b1;
            fast_val = op_in[1] ? a_i : '1;
        end else if ((op_in == MD_DIV || op_in == MD_REM) && a_i == MOST_NEG && b_i == '1) begin
            fast_hit = 1'b1;
            fast_val = op_in[1] ? '0 : a_i;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [XLEN+MUL_STEP-1:0] mul_part;
    logic [XLEN+MUL_STEP-1:0] mul_sum;
    logic [2*XLEN-1:0]        mul_next;

    // Add opnd * (low MUL_STEP multiplier bits) to the upper half, then
    // shift the whole accumulator right by MUL_STEP.
    always_comb begin
        mul_part = '0;
        for (int unsigned j = 0; j < MUL_STEP; j++) begin
            if (acc_q[j]) begin
                mul_part = mul_part + ({{MUL_STEP{1'b0}}, opnd_q} << j);
            end
        end
        mul_sum  = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_part;
        mul_next = {mul_sum, acc_q[XLEN-1:MUL_STEP]};
    end

    logic [XLEN:0]   div_trial;
    logic [XLEN:0]   div_diff;
    logic            div_borrow;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    // Restoring step: the XLEN+1-bit trial remainder only lives here; the
    // stored remainder is always below the divisor and fits in XLEN bits.
    always_comb begin
        div_trial  = {rem_q, acc_q[XLEN-1]};
        div_diff   = div_trial - {1'b0, opnd_q};
        div_borrow = div_diff[XLEN];
        rem_next   = div_borrow ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0];
        quo_next   = {acc_q[XLEN-2:0], ~div_borrow};
    end

    // ------------------------------------------------------------------
    // Sign fix-up
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   fix_val;

    md_negate #(.W(2*XLEN)) u_neg_prod (.value_i(acc_q), .neg_i(a_neg_q ^ b_neg_q), .result_o(prod_fix));
    md_negate #(.W(XLEN))   u_neg_quo  (.value_i(acc_q[XLEN-1:0]), .neg_i(a_neg_q ^ b_neg_q), .result_o(quo_fix));
    md_negate #(.W(XLEN))   u_neg_rem  (.value_i(rem_q), .neg_i(a_neg_q), .result_o(rem_fix));

    always_comb begin
        fix_val = '0;
        case (op_q)
            MD_MUL:                        fix_val = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               fix_val = quo_fix;
            default:                       fix_val = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = fast_hit ? ST_DONE : ST_CALC;
            ST_CALC:  if (cnt_q == '0) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q     <= MD_MUL;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        a_neg_q <= a_neg_in;
                        b_neg_q <= b_neg_in;
                        if (fast_hit) begin
                            result_q <= fast_val;
                        end else begin
                            opnd_q <= op_in[2] ? b_abs : a_abs;
                            acc_q  <= {{XLEN{1'b0}}, (op_in[2] ? a_abs : b_abs)};
                            rem_q  <= '0;
                            cnt_q  <= op_in[2] ? DIV_LOAD : MUL_LOAD;
                        end
                    end
                end
                ST_CALC: begin
                    if (!flush_i) begin
                        if (op_q[2]) begin
                            acc_q[XLEN-1:0] <= quo_next;
                            rem_q           <= rem_next;
                        end else begin
                            acc_q <= mul_next;
                        end
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_FIXUP: begin
                    if (!flush_i) begin
                        result_q <= fix_val;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign ready_o  = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter: one MUL_STEP=1 instance and
// one MUL_STEP=4 instance sharing clock and reset.
module tb_muldiv_iter;

    logic        clk;
    logic        rst;
    logic        req1, flush1;
    logic [2:0]  op1;
    logic [31:0] a1, b1;
    logic        busy1, rdy1;
    logic [31:0] res1;
    logic        req4, flush4;
    logic [2:0]  op4;
    logic [31:0] a4, b4;
    logic        busy4, rdy4;
    logic [31:0] res4;

    int tests = 0;
    int fails = 0;

    muldiv_iter #(.XLEN(32), .MUL_STEP(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .op_i(op1), .a_i(a1), .b_i(b1),
        .flush_i(flush1), .busy_o(busy1), .ready_o(rdy1), .result_o(res1)
    );

    muldiv_iter #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .req_i(req4), .op_i(op4), .a_i(a4), .b_i(b4),
        .flush_i(flush4), .busy_o(busy4), .ready_o(rdy4), .result_o(res4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op at a negedge, drop req after the accepting edge, and check
    // latency (negedges until ready_o), result, busy_o and the single-cycle pulse.
    task automatic run_op(input int which, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input string tag);
        int   lat;
        bit   busy_ok;
        logic rdy, bsy;
        logic [31:0] res;
        if (which == 4) begin req4 = 1'b1; op4 = op; a4 = a; b4 = b; end
        else            begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        @(posedge clk);
        lat = 0;
        busy_ok = 1'b1;
        res = '0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (which == 4) req4 = 1'b0; else req1 = 1'b0;
            rdy = (which == 4) ? rdy4 : rdy1;
            bsy = (which == 4) ? busy4 : busy1;
            if (bsy !== 1'b1) busy_ok = 1'b0;
            if (rdy === 1'b1) begin
                lat = n;
                res = (which == 4) ? res4 : res1;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, {32'h0, res}, {32'h0, exp});
        check({tag, " busy"}, {63'h0, busy_ok}, 64'h1);
        @(negedge clk);
        rdy = (which == 4) ? rdy4 : rdy1;
        check({tag, " pulse"}, {63'h0, rdy}, 64'h0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        rst = 1'b0;
        req1 = 1'b0; flush1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
        req4 = 1'b0; flush4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        check("rst busy", {63'h0, busy1}, 64'h0);
        check("rst ready", {63'h0, rdy1}, 64'h0);
        check("rst result", {32'h0, res1}, 64'h0);
        rst = 1'b1;
        @(negedge clk);

        // Multiply
        run_op(1, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "MUL 7*-3");
        run_op(1, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, "MULH min*min");
        run_op(1, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "MULHSU");
        run_op(1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "MULHU");
        run_op(1, 3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34, "MULH -1*2");

        // Divide
        run_op(1, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "DIV -7/2");
        run_op(1, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "REM -7/2");
        run_op(1, 3'b101, 32'd100,      32'd7,        32'd14,       34, "DIVU 100/7");
        run_op(1, 3'b111, 32'd100,      32'd7,        32'd2,        34, "REMU 100/7");
        run_op(1, 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, "DIV 7/-2");
        run_op(1, 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34, "REM 7/-2");
        run_op(1, 3'b110, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 34, "REM -8/-3");

        // Fast paths
        run_op(1, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, "DIVU 5/0");
        run_op(1, 3'b110, 32'd5,        32'd0,        32'd5,        1, "REM 5/0");
        run_op(1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "DIV ovf");
        run_op(1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, "REM ovf");
        run_op(1, 3'b000, 32'd0,        32'h12345678, 32'd0,        1, "MUL 0*x");

        // Flush beats a request in IDLE
        req1 = 1'b1; flush1 = 1'b1; op1 = 3'b000; a1 = 32'd3; b1 = 32'd4;
        @(negedge clk);
        check("flush idle busy", {63'h0, busy1}, 64'h0);
        req1 = 1'b0; flush1 = 1'b0;

        // Flush mid-CALC
        req1 = 1'b1; op1 = 3'b101; a1 = 32'd100; b1 = 32'd7;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            req1 = 1'b0;
        end
        flush1 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0;
        check("flush busy", {63'h0, busy1}, 64'h0);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy1 === 1'b1) seen = 1'b1;
        end
        check("flush no ready", {63'h0, seen}, 64'h0);
        run_op(1, 3'b000, 32'd3, 32'd4, 32'd12, 34, "MUL 3*4");

        // Reset mid-CALC
        req1 = 1'b1; op1 = 3'b000; a1 = 32'd7; b1 = 32'd5;
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            req1 = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("midrst busy", {63'h0, busy1}, 64'h0);
        check("midrst ready", {63'h0, rdy1}, 64'h0);
        check("midrst result", {32'h0, res1}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // MUL_STEP=4 instance
        run_op(4, 3'b000, 32'h12345678, 32'h10, 32'h23456780, 10, "S4 MUL");
        run_op(4, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 10, "S4 MULHU");

        // Request held high across completion: one idle cycle, then re-accept
        req4 = 1'b1; op4 = 3'b000; a4 = 32'd6; b4 = 32'd7;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (rdy4 === 1'b1) begin lat = n; break; end
        end
        check("S4 hold latency", 64'(lat), 64'd10);
        check("S4 hold result", {32'h0, res4}, 64'd42);
        @(negedge clk);
        check("S4 idle gap", {63'h0, busy4}, 64'h0);
        @(negedge clk);
        check("S4 reaccept", {63'h0, busy4}, 64'h1);
        req4 = 1'b0;
        lat = 0;
        for (int n = 2; n <= 30; n++) begin
            @(negedge clk);
            if (rdy4 === 1'b1) begin lat = n; break; end
        end
        check("S4 second latency", 64'(lat), 64'd10);
        check("S4 second result", {32'h0, res4}, 64'd42);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
